// File: rtl/data_memory_sized.sv
// Multi-cycle MIPS32 data memory with byte/half/word access, load extension,
// byte-lane stores, a Req/Busy/Done handshake and error reporting.
module data_memory_sized #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] ReadData,
    output logic        Error
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } stateT;

    stateT       state;
    logic [3:0]  count;
    logic [31:0] addrReg;
    logic [31:0] dataReg;
    logic [1:0]  sizeReg;
    logic        unsReg;
    logic        readReg;
    logic        writeReg;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             finish;
    logic             reqError;
    logic             storeEn;
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      memWord;
    logic [3:0]       laneEn;
    logic [31:0]      storeData;
    logic [7:0]       byteVal;
    logic [15:0]      halfVal;
    logic [31:0]      loadValue;

    assign accept  = (state == IDLE) && Req && (MemRead || MemWrite);
    assign finish  = (state == WAIT) && (count == 4'd0);
    assign wordIdx = addrReg[IDX_W+1:2];
    assign memWord = mem[wordIdx];

    // Every error source is judged on the latched request, never the live inputs.
    always_comb begin
        reqError = 1'b0;
        if (sizeReg == 2'b11)
            reqError = 1'b1;
        if (sizeReg == 2'b01 && addrReg[0])
            reqError = 1'b1;
        if (sizeReg == 2'b10 && addrReg[1:0] != 2'b00)
            reqError = 1'b1;
        if ({2'b00, addrReg[31:2]} >= 32'(DEPTH_WORDS))
            reqError = 1'b1;
        if (readReg && writeReg)
            reqError = 1'b1;
    end

    assign storeEn = finish && writeReg && !reqError;

    // Replicating the store data lets each lane pick its byte without shifting.
    always_comb begin
        laneEn    = 4'b0000;
        storeData = dataReg;
        case (sizeReg)
            2'b00: begin
                laneEn[addrReg[1:0]] = 1'b1;
                storeData            = {4{dataReg[7:0]}};
            end
            2'b01: begin
                laneEn    = addrReg[1] ? 4'b1100 : 4'b0011;
                storeData = {2{dataReg[15:0]}};
            end
            2'b10:   laneEn = 4'b1111;
            default: laneEn = 4'b0000;
        endcase
    end

    always_comb begin
        byteVal = memWord[7:0];
        case (addrReg[1:0])
            2'b00:   byteVal = memWord[7:0];
            2'b01:   byteVal = memWord[15:8];
            2'b10:   byteVal = memWord[23:16];
            default: byteVal = memWord[31:24];
        endcase
        halfVal = addrReg[1] ? memWord[31:16] : memWord[15:0];
    end

    always_comb begin
        loadValue = memWord;
        case (sizeReg)
            2'b00:   loadValue = unsReg ? {24'd0, byteVal} : {{24{byteVal[7]}}, byteVal};
            2'b01:   loadValue = unsReg ? {16'd0, halfVal} : {{16{halfVal[15]}}, halfVal};
            default: loadValue = memWord;
        endcase
    end

    // The array has no reset; an abandoned store cannot commit because reset forces IDLE.
    always_ff @(posedge Clk) begin
        if (storeEn) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i])
                    mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
            end
        end
    end

    // Request FSM: accept in IDLE, count down in WAIT, pulse Done from DONE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            addrReg  <= 32'd0;
            dataReg  <= 32'd0;
            sizeReg  <= 2'b00;
            unsReg   <= 1'b0;
            readReg  <= 1'b0;
            writeReg <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            ReadData <= 32'd0;
            Error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addrReg  <= Address;
                        dataReg  <= WriteData;
                        sizeReg  <= Size;
                        unsReg   <= Unsigned;
                        readReg  <= MemRead;
                        writeReg <= MemWrite;
                        count    <= CNT_INIT;
                        Busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state <= DONE;
                        Done  <= 1'b1;
                        Error <= reqError;
                        if (reqError)
                            ReadData <= 32'd0;
                        else if (readReg)
                            ReadData <= loadValue;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    Error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge Clk) disable iff (!Reset) Done |-> Busy);

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever Done is seen.
module tb_data_memory_sized;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        Clk;
    logic        Reset;
    logic        Req;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] ReadData;
    logic        Error;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          doneCycle;
    } expT;

    expT         sb[$];
    int          cycleCnt   = 0;
    int          busyRun    = 0;
    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] modelRd    = 32'd0;

    data_memory_sized #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .ReadData(ReadData), .Error(Error)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cycleCnt++;

    function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        expT e;
        busyRun = Busy ? busyRun + 1 : 0;
        if (Done === 1'b1) begin
            if (sb.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedDone: Done high at cycle %0d, expected no completion", cycleCnt);
            end else begin
                e = sb.pop_front();
                checkOutput("readData", ReadData, e.data);
                checkOutput("error", {31'd0, Error}, {31'd0, e.err});
                checkOutput("doneCycle", 32'(cycleCnt), 32'(e.doneCycle));
                checkOutput("busyCycles", 32'(busyRun), 32'(LAT + 1));
            end
        end
    end

    task automatic waitDrain();
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL timeout: %0d completions outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData,
                                 input logic expErr);
        expT e;
        @(negedge Clk);
        Req = 1'b1; MemRead = rd; MemWrite = wr; Size = sz;
        Unsigned = uns; Address = addr; WriteData = wdata;
        if (expErr)
            e.data = 32'd0;
        else if (rd)
            e.data = expData;
        else
            e.data = modelRd;
        modelRd     = e.data;
        e.err       = expErr;
        e.doneCycle = cycleCnt + 1 + LAT;
        sb.push_back(e);
        @(negedge Clk);
        Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        waitDrain();
    endtask

    task automatic pulseTest();
        expT e;
        int  n;
        @(negedge Clk);
        n   = cycleCnt;
        Req = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Size = 2'b10;
        Unsigned = 1'b0; Address = 32'h10;
        for (int k = 0; 1 + k * (LAT + 2) <= 10; k++) begin
            e.data      = 32'h123455EF;
            e.err       = 1'b0;
            e.doneCycle = n + 1 + k * (LAT + 2) + LAT;
            sb.push_back(e);
        end
        modelRd = 32'h123455EF;
        repeat (10) @(negedge Clk);
        Req = 1'b0; MemRead = 1'b0;
        waitDrain();
    endtask

    initial begin
        Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00;
        Unsigned = 1'b0; Address = 32'd0; WriteData = 32'd0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        checkOutput("resetBusy", {31'd0, Busy}, 32'd0);
        checkOutput("resetDone", {31'd0, Done}, 32'd0);
        checkOutput("resetReadData", ReadData, 32'd0);
        checkOutput("resetError", {31'd0, Error}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        // Word store/load and extension checks.
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'hFFFFFFDE, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'h000000DE, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'hFFFFDEAD, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'hFFFFFFEF, 1'b0);

        // Byte and halfword lane merging.
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAABBCC55, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEAD55EF, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h99991234, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h123455EF, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'h000055EF, 1'b0);

        // Illegal requests.
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0E, 32'hFFFFFFFF, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFFFFFF, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h123455EF, 1'b0);

        // Back-to-back Req and a request with no qualifier.
        pulseTest();
        @(negedge Clk);
        Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge Clk);
        checkOutput("noQualBusy", {31'd0, Busy}, 32'd0);
        Req = 1'b0;
        @(negedge Clk);
        checkOutput("noQualBusyAfter", {31'd0, Busy}, 32'd0);

        // Reset during WAIT abandons the store.
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11112222, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h11112222, 1'b0);
        @(negedge Clk);
        Req = 1'b1; MemWrite = 1'b1; Size = 2'b10; Address = 32'h20; WriteData = 32'hCAFEF00D;
        @(negedge Clk);
        Req = 1'b0; MemWrite = 1'b0;
        checkOutput("preResetBusy", {31'd0, Busy}, 32'd1);
        Reset = 1'b0;
        #1;
        checkOutput("midResetBusy", {31'd0, Busy}, 32'd0);
        checkOutput("midResetDone", {31'd0, Done}, 32'd0);
        checkOutput("midResetReadData", ReadData, 32'd0);
        checkOutput("midResetError", {31'd0, Error}, 32'd0);
        modelRd = 32'd0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h11112222, 1'b0);

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
